n8_pad_emulator: RTL and testbench

// - Device end of the N8 (NES-style) serial pad protocol: emulates a controller on the GPIO header.
// - Host drives latch/pulse; block parallel-loads 8 button states and returns them serially on data_out.
// - Sits between on-board buttons/switches and the header pins, so a second board or a Pico can poll
//   the FPGA exactly as it polls a real pad. data_out is active-low: 0 = pressed, 1 = released.

---
 rtl/n8_pkg.sv | 24 ++
 rtl/n8_sync_edge.sv | 34 +++
 rtl/n8_pad_emulator.sv | 171 +++++++++++++++++
 tb/tb_n8_pad_emulator.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/n8_pkg.sv
// Shared N8 pad definitions: button bit order and pad state encoding.
// The host-side driver uses the same indices so both ends agree on bit order.
`timescale 1ns/1ps
package n8_pkg;

  localparam int N8_NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } n8_pad_state_t;

endpackage

// File: rtl/n8_sync_edge.sv
// Multi-flop synchronizer followed by a registered rise/fall detector.
// level, rise and fall are all aligned to the same clock edge.
`timescale 1ns/1ps
module n8_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   synced;

  assign synced = chain[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      level <= synced;
      rise  <= synced & ~level;
      fall  <= ~synced & level;
    end
  end

endmodule

// File: rtl/n8_pad_emulator.sv
// N8 serial pad device end: latch loads buttons, pulse shifts them out active-low.
// Define N8_TURBO_EN to enable autofire on A/B driven by a latch-frame counter.
`timescale 1ns/1ps
module n8_pad_emulator
  import n8_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TURBO_DIV      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      latch_in,
  input  logic                      pulse_in,
  input  logic [N8_NUM_BUTTONS-1:0] buttons,
  input  logic                      turbo_a,
  input  logic                      turbo_b,
  output logic                      data_out,
  output logic                      frame_strobe,
  output logic                      busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_ONE = 1;
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES - 1);

  n8_pad_state_t             state;
  logic [N8_NUM_BUTTONS-1:0] sh;
  logic [N8_NUM_BUTTONS-1:0] eff;
  logic [2:0]                bit_cnt;
  logic [TW-1:0]             tcnt;
  logic                      expire;
  logic                      accept;

  logic latch_lvl, unused_latch_rise, latch_fall;
  logic unused_pulse_lvl, pulse_rise, pulse_fall;

  n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch (
    .clk   (clk),
    .rst   (rst),
    .pin   (latch_in),
    .level (latch_lvl),
    .rise  (unused_latch_rise),
    .fall  (latch_fall)
  );

  n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse (
    .clk   (clk),
    .rst   (rst),
    .pin   (pulse_in),
    .level (unused_pulse_lvl),
    .rise  (pulse_rise),
    .fall  (pulse_fall)
  );

  assign expire = (tcnt >= T_LIM);
  assign accept = ~latch_lvl & latch_fall & (state == ST_LOAD);

`ifdef N8_TURBO_EN
  localparam int FW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [FW-1:0] F_ONE = 1;
  localparam logic [FW-1:0] F_LIM = FW'(TURBO_DIV - 1);

  logic [FW-1:0] fcnt;
  logic          phase;

  // Phase flips once every TURBO_DIV accepted frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (accept) begin
      if (fcnt >= F_LIM) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + F_ONE;
      end
    end
  end

  always_comb begin
    eff        = buttons;
    eff[BTN_A] = buttons[BTN_A] & ~(turbo_a & phase);
    eff[BTN_B] = buttons[BTN_B] & ~(turbo_b & phase);
  end
`else
  logic unused_turbo;
  assign unused_turbo = turbo_a ^ turbo_b ^ accept;

  always_comb begin
    eff = buttons;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sh           <= '1;
      bit_cnt      <= '0;
      tcnt         <= '0;
      data_out     <= 1'b1;
      frame_strobe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (latch_lvl) begin
        // Latch wins over everything, including a coincident pulse edge.
        state    <= ST_LOAD;
        sh       <= ~eff;
        data_out <= ~eff[BTN_A];
        bit_cnt  <= '0;
        tcnt     <= '0;
        busy     <= 1'b1;
      end else begin
        unique case (state)
          ST_LOAD: begin
            if (latch_fall) begin
              state        <= ST_SHIFT;
              bit_cnt      <= '0;
              tcnt         <= '0;
              frame_strobe <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              data_out <= 1'b1;
              busy     <= 1'b0;
            end
          end
          ST_SHIFT: begin
            if (pulse_rise) begin
              tcnt <= '0;
              sh   <= {1'b1, sh[N8_NUM_BUTTONS-1:1]};
              if (bit_cnt == 3'd7) begin
                state    <= ST_DONE;
                data_out <= 1'b1;
                busy     <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                data_out <= sh[1];
              end
            end else if (pulse_fall) begin
              tcnt <= '0;
            end else if (expire) begin
              state    <= ST_IDLE;
              data_out <= 1'b1;
              busy     <= 1'b0;
            end else begin
              tcnt <= tcnt + T_ONE;
            end
          end
          ST_DONE: begin
            data_out <= 1'b1;
            busy     <= 1'b0;
            if (pulse_rise | pulse_fall) begin
              tcnt <= '0;
            end else if (expire) begin
              state <= ST_IDLE;
            end else begin
              tcnt <= tcnt + T_ONE;
            end
          end
          default: begin
            data_out <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n8_pad_emulator.sv
// Directed bench for n8_pad_emulator with a scoreboard of expected serial bits.
// Expected bit 0 pattern for turbo frames follows N8_TURBO_EN when defined.
`timescale 1ns/1ps
module tb_n8_pad_emulator;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       latch_in = 1'b0;
  logic       pulse_in = 1'b0;
  logic       turbo_a = 1'b0;
  logic       turbo_b = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       data_out;
  logic       frame_strobe;
  logic       busy;

  int   checks  = 0;
  int   passed  = 0;
  int   strobes = 0;
  int   s0;
  logic sb[$];

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_strobe === 1'b1) strobes++;

  n8_pad_emulator #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO),
    .TURBO_DIV      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .latch_in     (latch_in),
    .pulse_in     (pulse_in),
    .buttons      (buttons),
    .turbo_a      (turbo_a),
    .turbo_b      (turbo_b),
    .data_out     (data_out),
    .frame_strobe (frame_strobe),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sample(input string tag);
    logic e;
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL %s: got %0b expected <scoreboard empty>", tag, data_out);
    end else begin
      e = sb.pop_front();
      chk(tag, {15'd0, data_out}, {15'd0, e});
    end
  endtask

  task automatic latch_frame(input logic [7:0] b);
    buttons = b;
    for (int i = 0; i < 8; i++) sb.push_back(~b[i]);
    sb.push_back(1'b1);
    latch_in = 1'b1;
    #12us;
    latch_in = 1'b0;
    #3us;
  endtask

  task automatic pulse();
    pulse_in = 1'b1;
    #3us;
    pulse_in = 1'b0;
    #3us;
  endtask

  task automatic shift_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sample(tag);
      pulse();
    end
  endtask

  initial begin
    logic ph;
    #55;
    chk("rst_data", {15'd0, data_out}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_strobe", {15'd0, frame_strobe}, 16'd0);
    #45;
    rst = 1'b0;
    #1us;

    s0 = strobes;
    latch_frame(8'b0000_0101);
    chk("std_busy", {15'd0, busy}, 16'd1);
    shift_n(8, "std_bit");
    sample("std_after8");
    chk("std_strobe", 16'(strobes - s0), 16'd1);
    chk("std_busy_done", {15'd0, busy}, 16'd0);

    repeat (3) pulse();
    chk("ninth_data", {15'd0, data_out}, 16'd1);
    chk("ninth_busy", {15'd0, busy}, 16'd0);

    s0 = strobes;
    latch_frame(8'b0000_0101);
    shift_n(3, "abort_pre");
    sb.delete();
    latch_frame(8'h80);
    shift_n(8, "abort_bit");
    sample("abort_after8");
    chk("abort_strobe", 16'(strobes - s0), 16'd2);

    latch_frame(8'h0F);
    shift_n(2, "to_bit");
    chk("to_busy_pre", {15'd0, busy}, 16'd1);
    chk("to_data_pre", {15'd0, data_out}, 16'd0);
    #(TO * 20 * 5 / 4);
    chk("to_busy", {15'd0, busy}, 16'd0);
    chk("to_data", {15'd0, data_out}, 16'd1);
    sb.delete();
    pulse();
    chk("to_pulse_data", {15'd0, data_out}, 16'd1);

    latch_frame(8'hFF);
    shift_n(3, "rst_mid_bit");
    chk("rst_mid_busy_pre", {15'd0, busy}, 16'd1);
    s0 = strobes;
    rst = 1'b1;
    #1;
    chk("rst_mid_data", {15'd0, data_out}, 16'd1);
    chk("rst_mid_busy", {15'd0, busy}, 16'd0);
    chk("rst_mid_strobe", {15'd0, frame_strobe}, 16'd0);
    #100;
    rst = 1'b0;
    sb.delete();
    #1us;
    chk("rst_mid_nostrobe", 16'(strobes - s0), 16'd0);

    turbo_a = 1'b1;
    buttons = 8'h01;
    for (int f = 0; f < 6; f++) begin
`ifdef N8_TURBO_EN
      ph = ((f / 2) % 2) == 1;
`else
      ph = 1'b0;
`endif
      sb.push_back(ph);
      latch_in = 1'b1;
      #12us;
      latch_in = 1'b0;
      #3us;
      sample($sformatf("turbo_f%0d", f));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
